// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for common-anode 7-segment
// digits sharing one set of low-active segment lines.
//
// - Each digit slot lasts PRESCALE clocks.
// - The first BLANK_CYC clocks of every slot keep all anodes off, which
//   suppresses ghosting while the segment lines settle.
// - A newly loaded value waits in a pending register. It is adopted only at a
//   frame boundary, or straight away while the display is dark, so a frame
//   never mixes two values.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int BLANK_CYC  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic [4*NUM_DIGITS-1:0]         value,
  input  logic                            load,
  input  logic                            lz_suppress,
  output logic [6:0]                      seg,
  output logic [NUM_DIGITS-1:0]           an,
  output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
  output logic                            pending,
  output logic                            frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    BLANK_LIM  = PW'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_OFF    = 7'h7F;

  typedef enum logic {DARK, SCAN} state_t;

  state_t                   state_reg;
  logic [PW-1:0]            presc_cnt_reg;
  logic [IDX_W-1:0]         digit_idx_reg;
  logic [4*NUM_DIGITS-1:0]  active_reg;
  logic [4*NUM_DIGITS-1:0]  pending_val_reg;
  logic                     pending_reg;
  logic                     frame_done_reg;
  logic [6:0]               seg_reg;
  logic [NUM_DIGITS-1:0]    an_reg;

  logic                     scanning;
  logic                     slot_end;
  logic                     frame_end;
  logic                     commit;
  logic [3:0]               nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]    blank_digit;
  logic [3:0]               cur_nib;
  logic                     cur_blank;
  logic [NUM_DIGITS-1:0]    one_hot;

  // Low-active hex-to-7-segment map, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign scanning  = (state_reg == SCAN) && enable;
  assign slot_end  = (presc_cnt_reg == PRESC_LAST);
  assign frame_end = scanning && slot_end && (digit_idx_reg == IDX_LAST);
  // A waiting value is adopted at a frame boundary, or immediately when dark.
  assign commit    = pending_reg && (frame_end || (state_reg == DARK));

  // Split the active value into nibbles and mark leading zeros. A digit above
  // zero is blank when it and every more-significant nibble are all zero, so
  // digit 0 always shows something.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign nib[gi] = active_reg[4*gi +: 4];
    if (gi == 0) begin : g_lsd
      assign blank_digit[gi] = 1'b0;
    end else begin : g_upper
      assign blank_digit[gi] = lz_suppress &&
                               (active_reg[4*NUM_DIGITS-1:4*gi] == '0);
    end
  end

  assign cur_nib   = nib[digit_idx_reg];
  assign cur_blank = blank_digit[digit_idx_reg];
  assign one_hot   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_idx_reg;

  // Scan FSM. It updates the prescaler, the digit index, the value registers
  // and the registered anode/segment outputs together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= DARK;
      presc_cnt_reg   <= '0;
      digit_idx_reg   <= '0;
      active_reg      <= '0;
      pending_val_reg <= '0;
      pending_reg     <= 1'b0;
      frame_done_reg  <= 1'b0;
      seg_reg         <= SEG_OFF;
      an_reg          <= '1;
    end else begin
      frame_done_reg <= frame_end;

      if (commit) begin
        active_reg <= pending_val_reg;
      end
      // A load wins over a same-cycle commit. The commit takes the old
      // pending value, and the new value stays pending.
      if (load) begin
        pending_val_reg <= value;
        pending_reg     <= 1'b1;
      end else if (commit) begin
        pending_reg <= 1'b0;
      end

      case (state_reg)
        DARK: begin
          presc_cnt_reg <= '0;
          digit_idx_reg <= '0;
          seg_reg       <= SEG_OFF;
          an_reg        <= '1;
          if (enable) begin
            state_reg <= SCAN;
          end
        end
        default: begin
          if (!enable) begin
            state_reg     <= DARK;
            presc_cnt_reg <= '0;
            digit_idx_reg <= '0;
            seg_reg       <= SEG_OFF;
            an_reg        <= '1;
          end else begin
            if (slot_end) begin
              presc_cnt_reg <= '0;
              digit_idx_reg <= (digit_idx_reg == IDX_LAST) ? '0 : digit_idx_reg + 1'b1;
            end else begin
              presc_cnt_reg <= presc_cnt_reg + 1'b1;
            end
            if (presc_cnt_reg < BLANK_LIM) begin
              seg_reg <= SEG_OFF;
              an_reg  <= '1;
            end else begin
              an_reg  <= ~one_hot;
              seg_reg <= cur_blank ? SEG_OFF : hex_to_seg(cur_nib);
            end
          end
        end
      endcase
    end
  end

  assign seg        = seg_reg;
  assign an         = an_reg;
  assign digit_idx  = digit_idx_reg;
  assign pending    = pending_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed testbench for seg7_scan_ctrl with 4 digits, 4-cycle slots and
// 1 blank cycle per slot. Outputs are sampled on the falling clock edge.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int PS = 4;
  localparam int BC = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] value;
  logic        load;
  logic        lz_suppress;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        pending;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS(ND),
    .PRESCALE  (PS),
    .BLANK_CYC (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .value      (value),
    .load       (load),
    .lz_suppress(lz_suppress),
    .seg        (seg),
    .an         (an),
    .digit_idx  (digit_idx),
    .pending    (pending),
    .frame_done (frame_done)
  );

  // Expected segments are packed {d3,d2,d1,d0}.
  typedef struct {
    logic [15:0] val;
    logic        lz;
    logic [27:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  // Step until pending drops. On return we sit on the sample right after the
  // commit edge, which is a frame boundary when scanning.
  task automatic wait_commit(input string name);
    int k;
    k = 0;
    while (pending !== 1'b0 && k < 80) begin
      @(negedge clk);
      k++;
    end
    check({name, "_commit"}, 32'(pending), 32'd0);
    check({name, "_fd"}, 32'(frame_done), 32'd1);
  endtask

  // Checks one full frame cycle by cycle, starting from a frame boundary
  // sample. Each slot gives 1 blank cycle and then 3 lit cycles.
  task automatic check_frame(input logic [27:0] exp, input string name);
    logic [3:0] ea;
    logic [6:0] es;
    logic       slot_ok;
    logic       fd_ok;
    logic [3:0] got_an, want_an;
    logic [6:0] got_seg, want_seg;
    int         slot, pos;
    fd_ok    = 1'b1;
    slot_ok  = 1'b1;
    got_an   = '0;
    want_an  = '0;
    got_seg  = '0;
    want_seg = '0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      slot = j / 4;
      pos  = j % 4;
      if (pos == 0) begin
        slot_ok = 1'b1;
        ea = 4'hF;
        es = 7'h7F;
      end else begin
        ea = ~(4'(1) << slot);
        es = exp[slot*7 +: 7];
      end
      if ((an !== ea || seg !== es) && slot_ok) begin
        slot_ok  = 1'b0;
        got_an   = an;
        got_seg  = seg;
        want_an  = ea;
        want_seg = es;
      end
      if (frame_done !== (j == 15)) fd_ok = 1'b0;
      if (pos == 3) begin
        n_tests++;
        if (!slot_ok) begin
          n_fail++;
          $display("FAIL %s digit%0d: got an=%b seg=%h expected an=%b seg=%h",
                   name, slot, got_an, got_seg, want_an, want_seg);
        end else begin
          $display("[TB] ok %s digit%0d seg=%h", name, slot, exp[slot*7 +: 7]);
        end
      end
    end
    n_tests++;
    if (!fd_ok) begin
      n_fail++;
      $display("FAIL %s frame_done: got pulse pattern wrong expected 1 only at slot end of digit3", name);
    end
  endtask

  task automatic wait_idx(input logic [1:0] idx, input string name);
    int k;
    k = 0;
    while (digit_idx !== idx && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({name, "_idx_wait"}, 32'(digit_idx), 32'(idx));
  endtask

  task automatic wait_fd(input string name);
    int k;
    k = 0;
    while (frame_done !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check({name, "_fd_wait"}, 32'(frame_done), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] seen [4];
    logic [6:0] old_seg [4];
    int         ones_seen;
    int         k;

    vecs[0] = '{16'h12AF, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}};
    vecs[1] = '{16'h0003, 1'b0, {7'h40, 7'h40, 7'h40, 7'h30}};
    vecs[2] = '{16'h0003, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h30}};
    vecs[3] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[4] = '{16'h0100, 1'b1, {7'h7F, 7'h79, 7'h40, 7'h40}};
    vecs[5] = '{16'h89CD, 1'b0, {7'h00, 7'h10, 7'h46, 7'h21}};
    vecs[6] = '{16'h3070, 1'b1, {7'h30, 7'h40, 7'h78, 7'h40}};
    vecs[7] = '{16'h4567, 1'b0, {7'h19, 7'h12, 7'h02, 7'h78}};
    vecs[8] = '{16'h0E0B, 1'b1, {7'h7F, 7'h06, 7'h40, 7'h03}};

    rst = 1'b1; enable = 1'b0; load = 1'b0; lz_suppress = 1'b0; value = '0;
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    check("rst_idx", 32'(digit_idx), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("dark_an", 32'(an), 32'hF);
    check("dark_seg", 32'(seg), 32'h7F);
    enable = 1'b1;
    @(negedge clk);

    // Table-driven decode / suppression vectors.
    for (int i = 0; i < 9; i++) begin
      lz_suppress = vecs[i].lz;
      pulse_load(vecs[i].val);
      wait_commit($sformatf("vec%0d", i));
      check_frame(vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Mid-frame load: the old value stays visible until the boundary.
    lz_suppress = 1'b0;
    pulse_load(16'h12AF);
    wait_commit("t2_pre");
    old_seg[0] = 7'h0E; old_seg[1] = 7'h08; old_seg[2] = 7'h24; old_seg[3] = 7'h79;
    for (int d = 0; d < 4; d++) seen[d] = 7'h55;
    wait_idx(2'd1, "t2");
    value = 16'h0003;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check("t2_pending", 32'(pending), 32'd1);
    k = 0;
    while (pending !== 1'b0 && k < 40) begin
      for (int d = 1; d < 4; d++) begin
        if (an === ~(4'(1) << d)) seen[d] = seg;
      end
      @(negedge clk);
      k++;
    end
    check("t2_commit", 32'(pending), 32'd0);
    for (int d = 1; d < 4; d++) begin
      check($sformatf("t2_old_d%0d", d), 32'(seen[d]), 32'(old_seg[d]));
    end
    check_frame({7'h40, 7'h40, 7'h40, 7'h30}, "t2_new");
    lz_suppress = 1'b1;
    check_frame({7'h7F, 7'h7F, 7'h7F, 7'h30}, "t2_lz");

    // Two loads in one frame: only the last one is ever shown.
    lz_suppress = 1'b0;
    ones_seen = 0;
    pulse_load(16'h1111);
    repeat (3) @(negedge clk);
    pulse_load(16'h2222);
    check("t3_pending", 32'(pending), 32'd1);
    k = 0;
    while (pending !== 1'b0 && k < 40) begin
      if (seg === 7'h79) ones_seen++;
      @(negedge clk);
      k++;
    end
    check("t3_commit", 32'(pending), 32'd0);
    check_frame({7'h24, 7'h24, 7'h24, 7'h24}, "t3_2222");
    check("t3_no_1111", 32'(ones_seen), 32'd0);

    // Load on the frame-boundary cycle. The boundary commits the older value,
    // and the new one stays pending for one more frame.
    pulse_load(16'h4567);
    wait_idx(2'd3, "tb");
    repeat (3) @(negedge clk);
    value = 16'h89CD;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check("tb_pending", 32'(pending), 32'd1);
    check("tb_fd", 32'(frame_done), 32'd1);
    check_frame({7'h19, 7'h12, 7'h02, 7'h78}, "tb_first");
    check("tb_pending_cleared", 32'(pending), 32'd0);
    check_frame({7'h00, 7'h10, 7'h46, 7'h21}, "tb_second");

    // Disable mid-slot, load while dark, then re-enable.
    repeat (6) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("t5_dark_an", 32'(an), 32'hF);
    check("t5_dark_seg", 32'(seg), 32'h7F);
    check("t5_dark_idx", 32'(digit_idx), 32'd0);
    repeat (4) @(negedge clk);
    check("t5_hold_an", 32'(an), 32'hF);
    value = 16'hBEEF;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check("t5_pending_set", 32'(pending), 32'd1);
    @(negedge clk);
    check("t5_pending_clr", 32'(pending), 32'd0);
    lz_suppress = 1'b0;
    enable = 1'b1;
    k = 0;
    while (an === 4'hF && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t5_first_an", 32'(an), 32'hE);
    check("t5_first_seg", 32'(seg), 32'h0E);
    wait_fd("t5");
    check_frame({7'h03, 7'h06, 7'h06, 7'h0E}, "t5_beef");

    // Reset mid-scan drops both the active and the pending value.
    wait_idx(2'd2, "t6");
    value = 16'h0F0F;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check("t6_pending_pre", 32'(pending), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_an", 32'(an), 32'hF);
    check("t6_rst_seg", 32'(seg), 32'h7F);
    check("t6_rst_pending", 32'(pending), 32'd0);
    check("t6_rst_idx", 32'(digit_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_fd("t6");
    check_frame({7'h40, 7'h40, 7'h40, 7'h40}, "t6_zero");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
